texture_burst_responder: RTL and testbench

Memory-side responder for the texture tile-fetch burst protocol. It accepts burst read requests (`mem_req`/`mem_addr`/`mem_len`) from texture cache initiators and queues them. It reads pixels from a synchronous-read texture SRAM and streams them back one pixel per beat on `mem_rdata`/`mem_rvalid`/`mem_rlast`, honouring `mem_rready` backpressure. It sits between the texture cache and the texture backing store, and replaces the testbench memory model in the texture subsystem.

---
 rtl/texture_burst_responder_pkg.sv | 27 ++
 rtl/texture_burst_responder_if.sv | 32 +++
 rtl/texture_burst_responder_fifo.sv | 58 +++++
 rtl/texture_burst_responder.sv | 143 ++++++++++++++
 tb/tb_texture_burst_responder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/texture_burst_responder_pkg.sv
// ============================================================================
//  Module  : texture_mem_pkg
//  Brief   : Shared types and constants for the texture burst responder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package texture_mem_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } resp_state_t;

    localparam int REQ_ADDR_W              = 32;
    localparam int OBUF_DEPTH              = 2;
    localparam int DEFAULT_BYTES_PER_PIXEL = 4;
    localparam int PIX_SHIFT               = $clog2(DEFAULT_BYTES_PER_PIXEL);

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [15:0]           len;
    } tex_req_t;

endpackage

`default_nettype wire

// File: rtl/texture_burst_responder_if.sv
// ============================================================================
//  Module  : texture_burst_responder_if
//  Brief   : Burst request / beat return bus between texture cache and memory.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface texture_burst_responder_if #(
    parameter int ADDR_WIDTH       = 32,
    parameter int PIXEL_WIDTH_BITS = 32
);
    logic                        mem_req;
    logic [ADDR_WIDTH-1:0]       mem_addr;
    logic [15:0]                 mem_len;
    logic                        mem_req_ready;
    logic [PIXEL_WIDTH_BITS-1:0] mem_rdata;
    logic                        mem_rvalid;
    logic                        mem_rlast;
    logic                        mem_rready;

    modport master (
        output mem_req, mem_addr, mem_len, mem_rready,
        input  mem_req_ready, mem_rdata, mem_rvalid, mem_rlast
    );

    modport slave (
        input  mem_req, mem_addr, mem_len, mem_rready,
        output mem_req_ready, mem_rdata, mem_rvalid, mem_rlast
    );
endinterface

`default_nettype wire

// File: rtl/texture_burst_responder_fifo.sv
// ============================================================================
//  Module  : tex_sync_fifo
//  Brief   : Small synchronous FIFO with combinational head; DEPTH power of two.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tex_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         wdata,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int             c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw:0]  c_depth = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw:0]  c_one   = (c_aw + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + c_aw'(1);
            if (pop)  r_rptr <= r_rptr + c_aw'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read until a push has written it.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr] <= wdata;
    end

    assign rdata = r_mem[r_rptr];
    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);
    assign count = r_count;
endmodule

`default_nettype wire

// File: rtl/texture_burst_responder.sv
// ============================================================================
//  Module  : texture_burst_responder
//  Brief   : Queues texture burst reads, streams SRAM pixels with backpressure.
//            Optional TEXRESP_RANGE_CHECK_EN zero-fills beats beyond MEM_PIXELS.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module texture_burst_responder
    import texture_mem_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int BYTES_PER_PIXEL  = 4,
    parameter int PIXEL_WIDTH_BITS = BYTES_PER_PIXEL * 8,
    parameter int SRAM_AW          = 16,
    parameter int MEM_PIXELS       = 65536,
    parameter int REQ_DEPTH        = 4
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    texture_burst_responder_if.slave         bus,
    output logic                             sram_en,
    output logic [SRAM_AW-1:0]               sram_addr,
    input  wire logic [PIXEL_WIDTH_BITS-1:0] sram_rdata,
    output logic                             req_overflow,
    output logic                             range_err
);
    localparam int c_pix_shift = $clog2(BYTES_PER_PIXEL);
    localparam int c_ob_w      = PIXEL_WIDTH_BITS + 1;

    resp_state_t             r_state;
    logic [REQ_ADDR_W-1:0]   r_pix_idx;
    logic [15:0]             r_beats_left;
    logic                    r_inflight;
    logic                    r_inflight_last;
    logic                    r_inflight_zero;

    tex_req_t                w_req_in;
    tex_req_t                w_req_head;
    logic                    w_rq_push, w_rq_pop, w_rq_full, w_rq_empty;
    logic [$clog2(REQ_DEPTH):0] w_unused_rq_count;

    logic [c_ob_w-1:0]       w_ob_head;
    logic                    w_ob_pop, w_ob_empty, w_unused_ob_full;
    logic [$clog2(OBUF_DEPTH):0] w_ob_count;
    logic [2:0]              w_occupancy;

    logic                    w_issue, w_issue_last, w_load, w_oob;

    assign w_req_in.addr = REQ_ADDR_W'(bus.mem_addr[ADDR_WIDTH-1:0]);
    assign w_req_in.len  = bus.mem_len;

    // Popping before pushing lets a full queue accept a request in the pop cycle.
    assign w_rq_pop  = !w_rq_empty && ((r_state == IDLE) || w_issue_last);
    assign w_rq_push = bus.mem_req && (!w_rq_full || w_rq_pop);
    assign w_load    = w_rq_pop && (w_req_head.len != 16'd0);

    tex_sync_fifo #(.WIDTH($bits(tex_req_t)), .DEPTH(REQ_DEPTH)) u_req_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_rq_push),
        .wdata (w_req_in),
        .pop   (w_rq_pop),
        .rdata (w_req_head),
        .full  (w_rq_full),
        .empty (w_rq_empty),
        .count (w_unused_rq_count)
    );

    // Every issued or in-flight read must have a free output slot waiting for it.
    assign w_ob_pop     = !w_ob_empty && bus.mem_rready;
    assign w_occupancy  = 3'(w_ob_count) + 3'(r_inflight) - 3'(w_ob_pop);
    assign w_issue      = (r_state == STREAM) && (w_occupancy < 3'd2);
    assign w_issue_last = w_issue && (r_beats_left == 16'd1);

`ifdef TEXRESP_RANGE_CHECK_EN
    assign w_oob = (r_pix_idx >= REQ_ADDR_W'(MEM_PIXELS));
`else
    localparam int c_unused_mem_pixels = MEM_PIXELS;
    logic w_unused_pix_hi;
    assign w_oob           = 1'b0;
    assign w_unused_pix_hi = ^r_pix_idx[REQ_ADDR_W-1:SRAM_AW];
    assign range_err       = 1'b0;
`endif

    assign sram_en   = w_issue && !w_oob;
    assign sram_addr = r_pix_idx[SRAM_AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_pix_idx       <= '0;
            r_beats_left    <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_inflight_zero <= 1'b0;
            req_overflow    <= 1'b0;
`ifdef TEXRESP_RANGE_CHECK_EN
            range_err       <= 1'b0;
`endif
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
            r_inflight_zero <= w_issue && w_oob;
            if (bus.mem_req && w_rq_full && !w_rq_pop) req_overflow <= 1'b1;
`ifdef TEXRESP_RANGE_CHECK_EN
            if (w_issue && w_oob) range_err <= 1'b1;
`endif
            if (w_issue) begin
                r_pix_idx    <= r_pix_idx + REQ_ADDR_W'(1);
                r_beats_left <= r_beats_left - 16'd1;
            end
            case (r_state)
                IDLE:    if (w_load) r_state <= STREAM;
                STREAM:  if (w_issue_last && !w_load) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_load) begin
                r_pix_idx    <= w_req_head.addr >> c_pix_shift;
                r_beats_left <= w_req_head.len;
            end
        end
    end

    tex_sync_fifo #(.WIDTH(c_ob_w), .DEPTH(OBUF_DEPTH)) u_obuf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_inflight),
        .wdata ({(r_inflight_zero ? '0 : sram_rdata), r_inflight_last}),
        .pop   (w_ob_pop),
        .rdata (w_ob_head),
        .full  (w_unused_ob_full),
        .empty (w_ob_empty),
        .count (w_ob_count)
    );

    assign bus.mem_req_ready = !w_rq_full;
    assign bus.mem_rvalid    = !w_ob_empty;
    assign bus.mem_rdata     = w_ob_empty ? '0 : w_ob_head[c_ob_w-1:1];
    assign bus.mem_rlast     = !w_ob_empty && w_ob_head[0];
endmodule

`default_nettype wire

// File: tb/tb_texture_burst_responder.sv
// ============================================================================
//  Module  : tb_texture_burst_responder
//  Brief   : Directed table-driven bench for texture_burst_responder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_texture_burst_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sram_en;
    logic [15:0] sram_addr;
    logic [31:0] sram_rdata = '0;
    logic        req_overflow;
    logic        range_err;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic [31:0] got_d[$];
    logic        got_l[$];
    int          got_c[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    texture_burst_responder_if #(.ADDR_WIDTH(32), .PIXEL_WIDTH_BITS(32)) bus();

    texture_burst_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .sram_en      (sram_en),
        .sram_addr    (sram_addr),
        .sram_rdata   (sram_rdata),
        .req_overflow (req_overflow),
        .range_err    (range_err)
    );

    // SRAM model: SRAM[i] = i, one-cycle read latency
    always @(posedge clk) if (sram_en) sram_rdata <= 32'(sram_addr);

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Beat collector plus hold-while-stalled checker
    always @(negedge clk) begin
        if (rst_n && prev_stall) begin
            chk("stall_hold_valid", 32'(bus.mem_rvalid), 32'd1);
            chk("stall_hold_data", bus.mem_rdata, prev_d);
            chk("stall_hold_last", 32'(bus.mem_rlast), 32'(prev_l));
        end
        if (rst_n && bus.mem_rvalid && bus.mem_rready) begin
            got_d.push_back(bus.mem_rdata);
            got_l.push_back(bus.mem_rlast);
            got_c.push_back(cyc);
        end
        prev_stall = rst_n && bus.mem_rvalid && !bus.mem_rready;
        prev_d     = bus.mem_rdata;
        prev_l     = bus.mem_rlast;
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_beats();
        got_d.delete(); got_l.delete(); got_c.delete();
    endtask

    task automatic send(logic [31:0] a, logic [15:0] l);
        bus.mem_req = 1'b1; bus.mem_addr = a; bus.mem_len = l;
        tick();
        bus.mem_req = 1'b0;
    endtask

    // Wait (bounded) for n beats, optionally toggling rready, then confirm no extras
    task automatic wait_beats(string nm, int n, bit tog);
        int k = 0;
        while (got_d.size() < n && k < 400) begin
            if (tog) bus.mem_rready = ~bus.mem_rready;
            tick();
            k++;
        end
        bus.mem_rready = 1'b1;
        tick(8);
        chk({nm, "_beat_count"}, 32'(got_d.size()), 32'(n));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bus.mem_req = 1'b0; bus.mem_rready = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        clear_beats();
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        bit          tog;
        logic [31:0] first;
        int          lat;
    } vec_t;

    vec_t vt[3];

    initial begin
        int t0;
        int n;
        logic [31:0] exp_r[4];
        logic        exp_rerr;

        vt[0] = '{32'h0000_0100, 16'd64, 1'b0, 32'h40,  4};
        vt[1] = '{32'h0000_0040, 16'd16, 1'b1, 32'h10,  0};
        vt[2] = '{32'h0000_2008, 16'd1,  1'b0, 32'h802, 4};

        bus.mem_req = 1'b0; bus.mem_addr = '0; bus.mem_len = '0; bus.mem_rready = 1'b1;
        tick(3);
        chk("rst_rvalid", 32'(bus.mem_rvalid), 32'd0);
        chk("rst_rlast", 32'(bus.mem_rlast), 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_req_ready", 32'(bus.mem_req_ready), 32'd1);
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_overflow", 32'(req_overflow), 32'd0);
        chk("rst_range_err", 32'(range_err), 32'd0);
        rst_n = 1'b1;
        tick(2);

        for (int v = 0; v < 3; v++) begin
            clear_beats();
            t0 = cyc;
            send(vt[v].addr, vt[v].len);
            wait_beats($sformatf("vec%0d", v), int'(vt[v].len), vt[v].tog);
            for (int i = 0; i < got_d.size() && i < int'(vt[v].len); i++) begin
                chk($sformatf("vec%0d_data%0d", v, i), got_d[i], vt[v].first + 32'(i));
                chk($sformatf("vec%0d_last%0d", v, i), 32'(got_l[i]),
                    32'(i == int'(vt[v].len) - 1));
            end
            if (vt[v].lat != 0 && got_c.size() > 0)
                chk($sformatf("vec%0d_latency", v), 32'(got_c[0] - t0), 32'(vt[v].lat));
        end

        // Back-to-back bursts on consecutive cycles
        clear_beats();
        bus.mem_req = 1'b1; bus.mem_addr = 32'h0; bus.mem_len = 16'd4;
        tick();
        bus.mem_addr = 32'h1000;
        tick();
        bus.mem_req = 1'b0;
        wait_beats("b2b", 8, 1'b0);
        for (int i = 0; i < got_d.size() && i < 8; i++) begin
            chk($sformatf("b2b_data%0d", i), got_d[i], (i < 4) ? 32'(i) : 32'h400 + 32'(i - 4));
            chk($sformatf("b2b_last%0d", i), 32'(got_l[i]), 32'(i == 3 || i == 7));
            chk($sformatf("b2b_nobubble%0d", i), 32'(got_c[i] - got_c[0]), 32'(i));
        end

        // Zero-length request is discarded
        clear_beats();
        send(32'h200, 16'd0);
        send(32'h300, 16'd2);
        wait_beats("len0", 2, 1'b0);
        if (got_d.size() == 2) begin
            chk("len0_data0", got_d[0], 32'hC0);
            chk("len0_data1", got_d[1], 32'hC1);
            chk("len0_last0", 32'(got_l[0]), 32'd0);
            chk("len0_last1", 32'(got_l[1]), 32'd1);
        end

        // Overflow: first request drains into the stream, next four fill the queue
        bus.mem_rready = 1'b0;
        for (int r = 0; r < 5; r++) send(32'h0, 16'd8);
        chk("ovf_ready_full", 32'(bus.mem_req_ready), 32'd0);
        chk("ovf_not_yet", 32'(req_overflow), 32'd0);
        send(32'h0, 16'd8);
        chk("ovf_sticky", 32'(req_overflow), 32'd1);
        tick(3);
        chk("ovf_still_set", 32'(req_overflow), 32'd1);
        do_reset();
        chk("ovf_cleared", 32'(req_overflow), 32'd0);

        // Reset mid-burst
        send(32'h0, 16'd64);
        n = 0;
        while (got_d.size() < 10 && n < 100) begin tick(); n++; end
        chk("midrst_reached10", 32'(got_d.size() >= 10), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", 32'(bus.mem_rvalid), 32'd0);
        chk("midrst_rdata", bus.mem_rdata, 32'd0);
        chk("midrst_sram_en", 32'(sram_en), 32'd0);
        chk("midrst_req_ready", 32'(bus.mem_req_ready), 32'd1);
        tick(2);
        rst_n = 1'b1;
        n = got_d.size();
        tick(20);
        chk("midrst_no_more_beats", 32'(got_d.size()), 32'(n));

        // Pixel address at top of SRAM: wraps, or zero-fills with range check
`ifdef TEXRESP_RANGE_CHECK_EN
        exp_r = '{32'hFFFE, 32'hFFFF, 32'h0, 32'h0};
        exp_rerr = 1'b1;
`else
        exp_r = '{32'hFFFE, 32'hFFFF, 32'h0, 32'h1};
        exp_rerr = 1'b0;
`endif
        clear_beats();
        send(32'h0003_FFF8, 16'd4);
        wait_beats("edge", 4, 1'b0);
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            chk($sformatf("edge_data%0d", i), got_d[i], exp_r[i]);
            chk($sformatf("edge_last%0d", i), 32'(got_l[i]), 32'(i == 3));
        end
        chk("edge_range_err", 32'(range_err), 32'(exp_rerr));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
